vga_fb_ctrl: RTL and testbench
==============================

# vga_fb_ctrl

Parametrised VGA display controller. It generates configurable sync timing with selectable polarity, scans an on-chip indexed framebuffer with integer pixel scaling, and maps pixels through a programmable colour palette. The palette is double-buffered and committed at frame boundaries. The block sits between the pixel-producing logic (framebuffer write port, palette writes) and the board VGA DAC/connector; it runs entirely in the pixel clock domain.

## Interface
- HD, 1280: visible pixels per line
- HF / HR / HB, 48 / 112 / 248: horizontal front porch / sync / back porch, in pixels
- VD, 1024: visible lines
- VF / VR / VB, 1 / 3 / 38: vertical front porch / sync / back porch, in lines
- HS_POL / VS_POL, 1 / 1: active level of hsync / vsync
- BPP, 2: framebuffer bits per pixel; the palette has 2**BPP entries
- RGB_W, 12: output colour width
- SCALE, 1: pixel replication factor (1, 2 or 4); framebuffer is FB_W=HD/SCALE by FB_H=VD/SCALE
- XW / YW, 11 / 11: write-coordinate widths
- clk  in  1  pixel clock
- arstn  in  1  reset; arstn asynchronous, active-low; clock clk
- we_i  in  1  framebuffer write strobe
- x_i / y_i  in  XW / YW  framebuffer write coordinate (framebuffer units)
- pix_i  in  BPP  palette index to store
- pal_we_i  in  1  palette shadow write strobe
- pal_idx_i  in  BPP  palette entry
- pal_rgb_i  in  RGB_W  colour for that entry
- vga_hs_o / vga_vs_o  out  1  sync outputs
- rgb_o  out  RGB_W  pixel colour; 0 outside the display area
- de_o  out  1  display enable, aligned with rgb_o
- vblank_o  out  1  high while the vertical counter is outside the display region
- frame_start_o  out  1  one-cycle pulse at the start of each frame
- pal_pending_o  out  1  shadow palette modified, not yet committed

## Operation
- Counters: h in 0..HT-1 with HT=HR+HB+HD+HF. v in 0..VT-1 with VT=VR+VB+VD+VF. v increments when h=HT-1; both wrap to 0.
- Line order is sync [0,HR), back porch [HR,HR+HB), display [HR+HB,HR+HB+HD), front porch. Vertical order is identical.
- Active video: h and v both in their display windows. Pixel coordinates are px=h-(HR+HB), py=v-(VR+VB).
- Read address is (py/SCALE)*FB_W + px/SCALE. The divide is a shift; SCALE must be a power of two, checked by an elaboration assertion.
- Write: when we_i=1 and x_i<FB_W and y_i<FB_H, store fb[y_i*FB_W+x_i]=pix_i. Out-of-range writes are dropped silently.
- Framebuffer contents are not reset.
- Read and write to the same address in the same cycle: the read returns the old data.
- Palette: pal_we_i writes shadow[pal_idx_i]=pal_rgb_i and sets pal_pending_o. On the commit cycle (h=0, v=VR+VB+VD, the first vblank cycle), active palette <= shadow and pal_pending_o clears.
- A palette write in the commit cycle itself is taken into the shadow and leaves pal_pending_o=1; it is committed in the next frame.
- Reset: h=v=0. Shadow and active palettes are all 0. pal_pending_o=0. Pipeline is flushed.
- Reset values: vga_hs_o=!HS_POL, vga_vs_o=!VS_POL, rgb_o=0, de_o=0, vblank_o=0, frame_start_o=0.

## Timing
- Fixed 3-cycle pipeline from counter value to outputs:
  - stage 1: address and region flags registered
  - stage 2: framebuffer synchronous read
  - stage 3: palette lookup into the output register
- vga_hs_o, vga_vs_o, de_o, vblank_o and frame_start_o are delayed to match. For a counter state at cycle t, all outputs describing it appear at t+3.
- Sync is active (HS_POL / VS_POL) when h<HR / v<VR.
- frame_start_o corresponds to counter state h=0, v=0.
- First output cycle after reset release still reflects the reset pipeline values; the h=0, v=0 outputs appear at release+3.
- A write at cycle t is visible to a scan read issued at t+1 or later.
- Palette commit affects pixels whose stage-3 lookup occurs after the commit cycle. Commit is during vblank, so no visible frame is ever mixed.
- Asynchronous reset mid-frame clears all outputs immediately; scan restarts from h=v=0.

## Test plan
- Small config (HD=8, HF=2, HR=2, HB=2, VD=4, VF=1, VR=1, VB=1; HT=14, VT=7), HS_POL=VS_POL=0:
  - hs low 2 of every 14 cycles; vs low for 14 cycles every 98
  - de_o high 8 cycles per line on 4 lines
  - frame_start_o period 98
- Write pix=1 at (3,2); palette[1]=0xABC committed; wait one frame -> rgb_o=0xABC exactly at the de_o cycle for px=3, py=2, elsewhere rgb_o=palette[0].
- SCALE=2, same config: write (1,1)=2 with palette[2]=0x0F0 -> 0x0F0 on px 2..3, py 2..3 only.
- pal_we_i mid-display -> pal_pending_o=1 and output unchanged for the rest of the frame; the new colour appears from the next frame; pal_pending_o falls at the commit cycle. Also cover a write on the commit cycle itself.
- Write at x_i=FB_W or y_i=FB_H -> no framebuffer location changes, verified by a full-frame scan compare.
- Assert arstn low mid-display for 5 cycles -> all outputs at reset values during reset; after release the first frame_start_o arrives 3 cycles after release and timing matches scenario 1.

Source files
------------

// File: rtl/vga_fb_ctrl.sv
// rtl/vga_fb_ctrl.sv - VGA sync timing, scaled indexed framebuffer scan, double-buffered palette.
// Three-stage pipeline: address/region flags, framebuffer read, palette lookup.
module vga_fb_ctrl #(
  parameter int HD     = 1280,
  parameter int HF     = 48,
  parameter int HR     = 112,
  parameter int HB     = 248,
  parameter int VD     = 1024,
  parameter int VF     = 1,
  parameter int VR     = 3,
  parameter int VB     = 38,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int BPP    = 2,
  parameter int RGB_W  = 12,
  parameter int SCALE  = 1,
  parameter int XW     = 11,
  parameter int YW     = 11
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             we_i,
  input  logic [XW-1:0]    x_i,
  input  logic [YW-1:0]    y_i,
  input  logic [BPP-1:0]   pix_i,
  input  logic             pal_we_i,
  input  logic [BPP-1:0]   pal_idx_i,
  input  logic [RGB_W-1:0] pal_rgb_i,
  output logic             vga_hs_o,
  output logic             vga_vs_o,
  output logic [RGB_W-1:0] rgb_o,
  output logic             de_o,
  output logic             vblank_o,
  output logic             frame_start_o,
  output logic             pal_pending_o
);

  localparam int HT    = HR + HB + HD + HF;
  localparam int VT    = VR + VB + VD + VF;
  localparam int HCW   = $clog2(HT + 1);
  localparam int VCW   = $clog2(VT + 1);
  localparam int FB_W  = HD / SCALE;
  localparam int FB_H  = VD / SCALE;
  localparam int FB_N  = FB_W * FB_H;
  localparam int AW    = (FB_N > 1) ? $clog2(FB_N) : 1;
  localparam int SSH   = $clog2(SCALE);
  localparam int PAL_N = 2 ** BPP;

  localparam logic [HCW-1:0] H_LAST     = HCW'(HT - 1);
  localparam logic [HCW-1:0] H_SYNC_END = HCW'(HR);
  localparam logic [HCW-1:0] H_DISP_BEG = HCW'(HR + HB);
  localparam logic [HCW-1:0] H_DISP_END = HCW'(HR + HB + HD);
  localparam logic [VCW-1:0] V_LAST     = VCW'(VT - 1);
  localparam logic [VCW-1:0] V_SYNC_END = VCW'(VR);
  localparam logic [VCW-1:0] V_DISP_BEG = VCW'(VR + VB);
  localparam logic [VCW-1:0] V_DISP_END = VCW'(VR + VB + VD);
  localparam logic [XW:0]    FB_W_LIM   = (XW + 1)'(FB_W);
  localparam logic [YW:0]    FB_H_LIM   = (YW + 1)'(FB_H);

  if (SCALE < 1 || (SCALE & (SCALE - 1)) != 0) begin : g_bad_scale
    $error("vga_fb_ctrl: SCALE must be a power of two");
  end

  logic [HCW-1:0]   h_q, h_d;
  logic [VCW-1:0]   v_q, v_d;
  logic             h_disp, v_disp, commit;
  logic [HCW-1:0]   px;
  logic [VCW-1:0]   py;

  logic [AW-1:0]    s1_addr_q, s1_addr_d;
  logic             s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic             s1_vb_q, s1_vb_d, s1_fs_q, s1_fs_d;
  logic [BPP-1:0]   s2_pix_q, s2_pix_d;
  logic             s2_de_q, s2_de_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
  logic             s2_vb_q, s2_vb_d, s2_fs_q, s2_fs_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, vb_q, vb_d, fs_q, fs_d;

  logic [RGB_W-1:0] pal_shadow_q [PAL_N];
  logic [RGB_W-1:0] pal_shadow_d [PAL_N];
  logic [RGB_W-1:0] pal_active_q [PAL_N];
  logic [RGB_W-1:0] pal_active_d [PAL_N];
  logic             pal_pending_q, pal_pending_d;

  logic [BPP-1:0]   fb_mem [FB_N];
  logic             fb_wr_en;
  logic [AW-1:0]    fb_wr_addr;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end

    h_disp = (h_q >= H_DISP_BEG) && (h_q < H_DISP_END);
    v_disp = (v_q >= V_DISP_BEG) && (v_q < V_DISP_END);
    px     = h_q - H_DISP_BEG;
    py     = v_q - V_DISP_BEG;

    // Scaling is a pure shift; outside the display window the address is parked at 0.
    s1_addr_d = '0;
    if (h_disp && v_disp) begin
      s1_addr_d = AW'(32'(py >> SSH) * FB_W + 32'(px >> SSH));
    end
    s1_de_d = h_disp && v_disp;
    s1_hs_d = (h_q < H_SYNC_END) ? HS_POL : ~HS_POL;
    s1_vs_d = (v_q < V_SYNC_END) ? VS_POL : ~VS_POL;
    s1_vb_d = !v_disp;
    s1_fs_d = (h_q == '0) && (v_q == '0);

    s2_pix_d = fb_mem[s1_addr_q];
    s2_de_d  = s1_de_q;
    s2_hs_d  = s1_hs_q;
    s2_vs_d  = s1_vs_q;
    s2_vb_d  = s1_vb_q;
    s2_fs_d  = s1_fs_q;

    rgb_d = s2_de_q ? pal_active_q[s2_pix_q] : '0;
    de_d  = s2_de_q;
    hs_d  = s2_hs_q;
    vs_d  = s2_vs_q;
    vb_d  = s2_vb_q;
    fs_d  = s2_fs_q;

    // Commit copies the pre-write shadow, so a write landing on the commit cycle waits a frame.
    commit        = (h_q == '0) && (v_q == V_DISP_END);
    pal_shadow_d  = pal_shadow_q;
    pal_active_d  = pal_active_q;
    pal_pending_d = pal_pending_q;
    if (commit) begin
      pal_active_d  = pal_shadow_q;
      pal_pending_d = 1'b0;
    end
    if (pal_we_i) begin
      pal_shadow_d[pal_idx_i] = pal_rgb_i;
      pal_pending_d           = 1'b1;
    end

    fb_wr_en   = we_i && ({1'b0, x_i} < FB_W_LIM) && ({1'b0, y_i} < FB_H_LIM);
    fb_wr_addr = AW'(32'(y_i) * FB_W + 32'(x_i));
  end

  always_ff @(posedge clk) begin
    if (fb_wr_en) begin
      fb_mem[fb_wr_addr] <= pix_i;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      h_q           <= '0;
      v_q           <= '0;
      s1_addr_q     <= '0;
      s1_de_q       <= 1'b0;
      s1_hs_q       <= ~HS_POL;
      s1_vs_q       <= ~VS_POL;
      s1_vb_q       <= 1'b0;
      s1_fs_q       <= 1'b0;
      s2_pix_q      <= '0;
      s2_de_q       <= 1'b0;
      s2_hs_q       <= ~HS_POL;
      s2_vs_q       <= ~VS_POL;
      s2_vb_q       <= 1'b0;
      s2_fs_q       <= 1'b0;
      rgb_q         <= '0;
      de_q          <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      vb_q          <= 1'b0;
      fs_q          <= 1'b0;
      pal_pending_q <= 1'b0;
      for (int i = 0; i < PAL_N; i++) begin
        pal_shadow_q[i] <= '0;
        pal_active_q[i] <= '0;
      end
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      s1_addr_q     <= s1_addr_d;
      s1_de_q       <= s1_de_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_vb_q       <= s1_vb_d;
      s1_fs_q       <= s1_fs_d;
      s2_pix_q      <= s2_pix_d;
      s2_de_q       <= s2_de_d;
      s2_hs_q       <= s2_hs_d;
      s2_vs_q       <= s2_vs_d;
      s2_vb_q       <= s2_vb_d;
      s2_fs_q       <= s2_fs_d;
      rgb_q         <= rgb_d;
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      vb_q          <= vb_d;
      fs_q          <= fs_d;
      pal_pending_q <= pal_pending_d;
      pal_shadow_q  <= pal_shadow_d;
      pal_active_q  <= pal_active_d;
    end
  end

  assign vga_hs_o      = hs_q;
  assign vga_vs_o      = vs_q;
  assign rgb_o         = rgb_q;
  assign de_o          = de_q;
  assign vblank_o      = vb_q;
  assign frame_start_o = fs_q;
  assign pal_pending_o = pal_pending_q;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb/tb_vga_fb_ctrl.sv - scoreboard bench for vga_fb_ctrl, small timing, SCALE=1 and SCALE=2 side by side.
module tb_vga_fb_ctrl;

  localparam int HT = 14;
  localparam int VT = 7;

  logic        clk = 1'b0;
  logic        arstn;
  logic        we, pal_we;
  logic [10:0] x, y;
  logic [1:0]  pix, pal_idx;
  logic [11:0] pal_rgb;
  logic        hs1, vs1, de1, vb1, fs1, pp1;
  logic        hs2, vs2, de2, vb2, fs2, pp2;
  logic [11:0] rgb1, rgb2;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          armed = 1'b0;
  logic [11:0] q1[$];
  logic [11:0] q2[$];

  always #5 clk = ~clk;

  vga_fb_ctrl #(
    .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(1), .VB(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .BPP(2), .RGB_W(12), .SCALE(1), .XW(11), .YW(11)
  ) u_dut1 (
    .clk(clk), .arstn(arstn), .we_i(we), .x_i(x), .y_i(y), .pix_i(pix),
    .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_rgb_i(pal_rgb),
    .vga_hs_o(hs1), .vga_vs_o(vs1), .rgb_o(rgb1), .de_o(de1), .vblank_o(vb1),
    .frame_start_o(fs1), .pal_pending_o(pp1)
  );

  vga_fb_ctrl #(
    .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(1), .VB(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .BPP(2), .RGB_W(12), .SCALE(2), .XW(11), .YW(11)
  ) u_dut2 (
    .clk(clk), .arstn(arstn), .we_i(we), .x_i(x), .y_i(y), .pix_i(pix),
    .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_rgb_i(pal_rgb),
    .vga_hs_o(hs2), .vga_vs_o(vs2), .rgb_o(rgb2), .de_o(de2), .vblank_o(vb2),
    .frame_start_o(fs2), .pal_pending_o(pp2)
  );

  // Counter state index since reset release; outputs during cycle cyc describe state cyc-3.
  always @(posedge clk or negedge arstn) begin
    if (!arstn) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Framebuffer contents after the setup writes, for each geometry.
  function automatic int idx1(input int px, input int py);
    if (px == 1 && py == 1) return 2;
    if (px == 3 && py == 2) return 1;
    if ((px == 4 && py == 0) || (px == 0 && py == 2)) return 3;
    return 0;
  endfunction

  function automatic int idx2(input int px, input int py);
    if (px / 2 == 1 && py / 2 == 1) return 2;
    return 0;
  endfunction

  task automatic push_frame(input logic [11:0] p0, input logic [11:0] p1,
                            input logic [11:0] p2, input logic [11:0] p3);
    logic [11:0] pal [4];
    pal[0] = p0; pal[1] = p1; pal[2] = p2; pal[3] = p3;
    for (int py = 0; py < 4; py++) begin
      for (int px = 0; px < 8; px++) begin
        q1.push_back(pal[idx1(px, py)]);
        q2.push_back(pal[idx2(px, py)]);
      end
    end
  endtask

  task automatic wait_hv(input int h, input int v);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(((cyc % HT) == h) && (((cyc / HT) % VT) == v)) && n < 2000);
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_hv timeout act=none exp=h%0d_v%0d", h, v);
    end
  endtask

  task automatic wr_fb(input int xx, input int yy, input int p);
    we = 1'b1; x = 11'(xx); y = 11'(yy); pix = 2'(p);
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic wr_pal(input int idx, input logic [11:0] rgb);
    pal_we = 1'b1; pal_idx = 2'(idx); pal_rgb = rgb;
    @(posedge clk); #1;
    pal_we = 1'b0;
  endtask

  task automatic chk_pend(input string name, input logic exp);
    chk({name, "_dut1"}, 32'(pp1), 32'(exp));
    chk({name, "_dut2"}, 32'(pp2), 32'(exp));
  endtask

  // Sync / enable / blanking / frame-start timing, and rgb blanking outside de.
  always @(negedge clk) begin : timing_chk
    int s, h, v;
    logic [4:0] e;
    if (!arstn || cyc < 3) begin
      e = 5'b11000;
    end else begin
      s = cyc - 3;
      h = s % HT;
      v = (s / HT) % VT;
      e = {h >= 2, v >= 1, (h >= 4 && h < 12 && v >= 2 && v < 6), !(v >= 2 && v < 6), (h == 0 && v == 0)};
    end
    checks += 2;
    if ({hs1, vs1, de1, vb1, fs1} !== e) begin
      errors++;
      $display("FAIL timing_dut1 cyc=%0d act=%b exp=%b", cyc, {hs1, vs1, de1, vb1, fs1}, e);
    end
    if ({hs2, vs2, de2, vb2, fs2} !== e) begin
      errors++;
      $display("FAIL timing_dut2 cyc=%0d act=%b exp=%b", cyc, {hs2, vs2, de2, vb2, fs2}, e);
    end
    if (!de1) begin
      checks++;
      if (rgb1 !== 12'h000) begin errors++; $display("FAIL blank_dut1 cyc=%0d act=%h exp=000", cyc, rgb1); end
    end
    if (!de2) begin
      checks++;
      if (rgb2 !== 12'h000) begin errors++; $display("FAIL blank_dut2 cyc=%0d act=%h exp=000", cyc, rgb2); end
    end
  end

  always @(negedge clk) begin : sb_mon
    logic [11:0] e;
    int s, px, py;
    s  = cyc - 3;
    px = (s % HT) - 4;
    py = ((s / HT) % VT) - 2;
    if (arstn && armed && de1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL pix_dut1 px=%0d py=%0d act=%h exp=none", px, py, rgb1);
      end else begin
        e = q1.pop_front();
        if (rgb1 !== e) begin errors++; $display("FAIL pix_dut1 px=%0d py=%0d act=%h exp=%h", px, py, rgb1, e); end
      end
    end
    if (arstn && armed && de2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL pix_dut2 px=%0d py=%0d act=%h exp=none", px, py, rgb2);
      end else begin
        e = q2.pop_front();
        if (rgb2 !== e) begin errors++; $display("FAIL pix_dut2 px=%0d py=%0d act=%h exp=%h", px, py, rgb2, e); end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    we = 1'b0; x = '0; y = '0; pix = '0;
    pal_we = 1'b0; pal_idx = '0; pal_rgb = '0;
    arstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_pend("rst_pending", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;

    // Clear both framebuffers, then directed pixels and out-of-range writes.
    for (int yy = 0; yy < 4; yy++) begin
      for (int xx = 0; xx < 8; xx++) wr_fb(xx, yy, 0);
    end
    wr_fb(3, 2, 1);
    wr_fb(1, 1, 2);
    wr_fb(4, 0, 3);
    wr_fb(0, 2, 3);
    wr_fb(8, 0, 1);
    wr_fb(0, 4, 1);
    wr_fb(8, 3, 2);
    wr_pal(0, 12'h123);
    wr_pal(1, 12'hABC);
    wr_pal(2, 12'h0F0);
    wr_pal(3, 12'hF00);
    chk_pend("pend_setup", 1'b1);
    wait_hv(0, 6);
    chk_pend("pend_commit_cyc0", 1'b1);
    wait_hv(1, 6);
    chk_pend("pend_clear0", 1'b0);

    // Frame 1: first committed palette; shadow write mid-display must not show.
    wait_hv(0, 2);
    push_frame(12'h123, 12'hABC, 12'h0F0, 12'hF00);
    armed = 1'b1;
    wait_hv(6, 3);
    wr_pal(1, 12'h555);
    chk_pend("pend_mid", 1'b1);
    wait_hv(0, 6);
    chk_pend("pend_commit_cyc1", 1'b1);
    wait_hv(1, 6);
    chk_pend("pend_clear1", 1'b0);

    // Frame 2: new colour visible; palette write exactly on the commit cycle.
    wait_hv(0, 2);
    push_frame(12'h123, 12'h555, 12'h0F0, 12'hF00);
    wait_hv(0, 6);
    wr_pal(2, 12'h00F);
    chk_pend("pend_commit_wr", 1'b1);

    // Frame 3: commit-cycle write not yet active; it commits at the end of this frame.
    wait_hv(0, 2);
    push_frame(12'h123, 12'h555, 12'h0F0, 12'hF00);
    wait_hv(0, 6);
    chk_pend("pend_commit_cyc3", 1'b1);
    wait_hv(1, 6);
    chk_pend("pend_clear3", 1'b0);

    // Frame 4: deferred colour now visible.
    wait_hv(0, 2);
    push_frame(12'h123, 12'h555, 12'h00F, 12'hF00);

    // Frame 5: pending write, then asynchronous reset mid-display.
    wait_hv(0, 0);
    armed = 1'b0;
    chk("drain_f4_dut1", q1.size(), 0);
    chk("drain_f4_dut2", q2.size(), 0);
    wr_pal(0, 12'hFFF);
    chk_pend("pend_prerst", 1'b1);
    wait_hv(6, 3);
    arstn = 1'b0;
    #1;
    chk_pend("pend_async_rst", 1'b0);
    repeat (5) @(posedge clk);
    #1;
    arstn = 1'b1;

    // Palettes reset to 0 while framebuffer data is retained: whole display is 0.
    wait_hv(0, 2);
    push_frame(12'h000, 12'h000, 12'h000, 12'h000);
    armed = 1'b1;
    wait_hv(2, 6);
    chk("drain_end_dut1", q1.size(), 0);
    chk("drain_end_dut2", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
